minterm_scanner: RTL and testbench
==================================

MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 Parameter N_VARS, default 4, SHALL be the number of Boolean inputs; the table width is 2**N_VARS, and the legal range is 2..6.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a scan of truth_table; sampled only in IDLE.
REQ-005 truth_table  input  2**N_VARS  SHALL be the function's truth table; bit i is the output for input vector i, with MSB variable first.
REQ-006 idx  output  N_VARS  SHALL be the current minterm index.
REQ-007 idx_valid  output  1  SHALL mean idx holds a valid term.
REQ-008 idx_ready  input  1  SHALL be the consumer's acceptance of idx.
REQ-009 busy  output  1  SHALL be high in SCAN and DONE.
REQ-010 done  output  1  SHALL be a one-cycle pulse at the end of a scan.
REQ-011 count  output  N_VARS+1  SHALL be the number of terms accepted in the current or last scan.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE; no other states are reachable.
REQ-013 IDLE with start=1 SHALL do the following at that edge: latch truth_table into an internal register, clear ptr and count, and go to SCAN.
REQ-014 IDLE with start=0 SHALL hold; start in SCAN or DONE SHALL be ignored, and the latched table is unaffected by later truth_table changes.
REQ-015 In SCAN, idx SHALL equal ptr and idx_valid SHALL equal the latched table bit [ptr], combinationally from registered state.
REQ-016 In SCAN, ptr SHALL advance by 1 when the table bit is 0, or when idx_valid and idx_ready are both 1; otherwise ptr SHALL hold.
REQ-017 Once raised, idx_valid SHALL stay high with idx stable until accepted (no retraction).
REQ-018 count SHALL increment by 1 on each accepted term; maximum 2**N_VARS with no wrap.
REQ-019 SCAN SHALL move to DONE on the edge where ptr = 2**N_VARS-1 advances; ptr SHALL NOT wrap into a second pass.
REQ-020 DONE SHALL last exactly one cycle with done=1, idx_valid=0, then return to IDLE.
REQ-021 Timing: the first candidate SHALL be visible in the cycle after start; with idx_ready tied high, a scan SHALL take 2**N_VARS SCAN cycles plus 1 DONE cycle.
REQ-022 An all-zero table SHALL produce no idx_valid, done after 2**N_VARS SCAN cycles, and count=0.
REQ-023 Outside SCAN, idx SHALL read 0.

Reset
REQ-024 rst=1 SHALL force the following at the next edge, overriding all other inputs including mid-scan: state=IDLE, ptr=0, count=0, latched table=0, idx_valid=0, done=0, busy=0, idx=0.

Configuration
REQ-025 With MINTERM_SCANNER_MAXTERM_EN defined, the scanner SHALL emit indices of 0 bits (maxterms) instead of 1 bits: the inverted latched table is used in REQ-015/016/022, so an all-ones table emits nothing.
REQ-026 Without MINTERM_SCANNER_MAXTERM_EN, only minterms (1 bits) SHALL be emitted.
REQ-027 Ports and timing SHALL be identical in both builds.

Structure
REQ-028 A shared package minterm_pkg SHALL hold the FSM state enum (IDLE/SCAN/DONE) and the constant TABLE_W = 2**N_VARS default helper.
REQ-029 The block SHALL be a single module; no sub-module is needed.

Verification
REQ-030 Scenario 1: table=16'h6EEE, idx_ready=1, start pulse -> idx 1,2,3,5,6,7,9,10,11,13,14 in order; done at cycle 17 after start; count=11.
REQ-031 Scenario 2: table=16'h0000 -> no idx_valid; done pulse after 16 SCAN cycles; count=0.
REQ-032 Scenario 3: table=16'h8001, idx_ready=0 for 5 cycles -> idx=0 held valid and stable for 5 cycles; after ready, 15 is emitted; count=2.
REQ-033 Scenario 4: start during SCAN and truth_table changed mid-scan -> output sequence unchanged; no restart.
REQ-034 Scenario 5: rst asserted at the 4th SCAN cycle of 16'hFFFF -> next cycle IDLE, all outputs 0; a new start rescans from idx 0.
REQ-035 Scenario 6 (MAXTERM build): table=16'hFFFE -> single idx 0, count=1.

Source files
------------

// File: rtl/minterm_pkg.sv
// -----------------------------------------------------------------------------
// minterm_pkg
// Shared definitions for the minterm scanner.
//   state_e        : scanner FSM states (IDLE / SCAN / DONE)
//   DEFAULT_N_VARS : default number of Boolean inputs
//   TABLE_W        : truth-table width for the default input count
//   table_w()      : truth-table width for an arbitrary input count
// -----------------------------------------------------------------------------
package minterm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_N_VARS = 4;

    // Width of a truth table over n variables: one bit per input vector.
    function automatic int table_w(input int n);
        return 1 << n;
    endfunction

    localparam int TABLE_W = table_w(DEFAULT_N_VARS);

endpackage : minterm_pkg

// File: rtl/minterm_scanner.sv
// -----------------------------------------------------------------------------
// minterm_scanner
// Latches a truth table on start and walks it from index 0 upward, presenting
// the index of every selected term on a valid/ready handshake. Zero bits are
// skipped at one index per cycle; a presented term is held until accepted.
//
// Build option: define MINTERM_SCANNER_MAXTERM_EN to emit the indices of the
// 0 bits (maxterms) instead of the 1 bits. Ports and timing are unchanged.
//
// Parameters
//   N_VARS       number of Boolean inputs (legal 2..6); table is 2**N_VARS wide
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a scan (only honoured while idle)
//   truth_table  bit i = function output for input vector i
//   idx          current term index (0 outside a scan)
//   idx_valid    idx holds a selected term
//   idx_ready    consumer accepts idx
//   busy         high while scanning and in the done cycle
//   done         one-cycle pulse ending a scan
//   count        number of terms accepted in the current or last scan
// -----------------------------------------------------------------------------
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int N_VARS = DEFAULT_N_VARS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [(1 << N_VARS)-1:0]    truth_table,
    output logic [N_VARS-1:0]           idx,
    output logic                        idx_valid,
    input  logic                        idx_ready,
    output logic                        busy,
    output logic                        done,
    output logic [N_VARS:0]             count
);

    localparam int                  TW        = table_w(N_VARS);
    localparam logic [N_VARS-1:0]   PTR_LAST  = '1;
    localparam logic [N_VARS-1:0]   PTR_ONE   = N_VARS'(1);
    localparam logic [N_VARS:0]     COUNT_MAX = (N_VARS+1)'(TW);
    localparam logic [N_VARS:0]     COUNT_ONE = (N_VARS+1)'(1);

    state_e                 state_q, state_d;
    logic [TW-1:0]          table_q, table_d;
    logic [N_VARS-1:0]      ptr_q,   ptr_d;
    logic [N_VARS:0]        count_q, count_d;

    logic [TW-1:0]          sel_table;
    logic                   in_scan;
    logic                   cur_bit;
    logic                   advance;
    logic                   accept;

    // The maxterm build simply scans the inverted latched table; everything
    // downstream sees a "selected" bit and is otherwise identical.
`ifdef MINTERM_SCANNER_MAXTERM_EN
    assign sel_table = ~table_q;
`else
    assign sel_table = table_q;
`endif

    assign in_scan = (state_q == SCAN);
    assign cur_bit = sel_table[ptr_q];
    // Unselected bits are skipped unconditionally; a selected bit waits for
    // the consumer, which also guarantees idx_valid is never retracted.
    assign accept  = in_scan & cur_bit & idx_ready;
    assign advance = in_scan & (~cur_bit | idx_ready);

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            table_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Leaving on the advance of the last index means the pointer
                // never wraps into a second pass.
                if (advance && (ptr_q == PTR_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        table_d = table_q;
        ptr_d   = ptr_q;
        count_d = count_q;

        if ((state_q == IDLE) && start) begin
            table_d = truth_table;
            ptr_d   = '0;
            count_d = '0;
        end else begin
            // At the last index the pointer parks; the FSM leaves SCAN.
            if (advance && (ptr_q != PTR_LAST)) begin
                ptr_d = ptr_q + PTR_ONE;
            end
            if (accept && (count_q != COUNT_MAX)) begin
                count_d = count_q + COUNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        idx       = '0;
        idx_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            SCAN: begin
                idx       = ptr_q;
                idx_valid = cur_bit;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign count = count_q;

endmodule : minterm_scanner

// File: tb/tb_minterm_scanner.sv
// -----------------------------------------------------------------------------
// tb_minterm_scanner
// Self-checking bench for minterm_scanner (N_VARS = 4). Tables are written in
// terms of the selected bits; under MINTERM_SCANNER_MAXTERM_EN the raw table
// driven to the DUT is the complement, so the same expectations hold.
// -----------------------------------------------------------------------------
module tb_minterm_scanner;

    localparam int NV = 4;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [TW-1:0]     truth_table;
    logic [NV-1:0]     idx;
    logic              idx_valid;
    logic              idx_ready;
    logic              busy;
    logic              done;
    logic [NV:0]       count;

    int total = 0;
    int bad   = 0;

    minterm_scanner #(.N_VARS(NV)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .truth_table (truth_table),
        .idx         (idx),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] sel;        // table of selected terms
        int            ready_pct;  // chance of idx_ready per cycle
        int            hold0;      // cycles of forced idx_ready=0 at start
        logic          disturb;    // toggle start/truth_table during scan
        int            exp_count;  // expected terms accepted
    } vec_t;

    // Raw table driven to the DUT that selects the given terms.
    function automatic logic [TW-1:0] raw_of(input logic [TW-1:0] sel);
`ifdef MINTERM_SCANNER_MAXTERM_EN
        return ~sel;
`else
        return sel;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int exp_cnt);
        @(negedge clk);
        chk({tag, "_idx"},   int'(idx),       0);
        chk({tag, "_valid"}, int'(idx_valid), 0);
        chk({tag, "_busy"},  int'(busy),      0);
        chk({tag, "_done"},  int'(done),      0);
        chk({tag, "_count"}, int'(count),     exp_cnt);
    endtask

    // Runs one scan. The model walks positions 0..15: a selected position is
    // presented until the cycle ready is high, an unselected one lasts one
    // cycle. Returns the number of terms the model saw accepted.
    task automatic run_scan(input logic [TW-1:0] sel, input int ready_pct,
                            input int hold0, input logic disturb,
                            output int n_acc);
        int pos;
        int cyc;
        logic exp_valid;
        pos   = 0;
        cyc   = 0;
        n_acc = 0;
        truth_table = raw_of(sel);
        start       = 1'b1;
        idx_ready   = 1'b0;
        step();
        start = 1'b0;
        while (pos < TW && cyc < 2000) begin
            idx_ready = (cyc < hold0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
            if (disturb) begin
                start       = 1'($urandom_range(0, 1));
                truth_table = TW'($urandom);
            end
            exp_valid = sel[pos];
            @(negedge clk);
            chk("scan_idx",   int'(idx),       pos);
            chk("scan_valid", int'(idx_valid), int'(exp_valid));
            chk("scan_busy",  int'(busy),      1);
            chk("scan_done",  int'(done),      0);
            chk("scan_count", int'(count),     n_acc);
            if (!exp_valid || idx_ready) begin
                if (exp_valid) n_acc++;
                pos++;
            end
            cyc++;
            step();
        end
        if (pos < TW) chk("scan_timeout", pos, TW);
        start = 1'b0;
        @(negedge clk);
        chk("end_done",  int'(done),      1);
        chk("end_busy",  int'(busy),      1);
        chk("end_valid", int'(idx_valid), 0);
        chk("end_idx",   int'(idx),       0);
        chk("end_count", int'(count),     n_acc);
        step();
        check_idle("post", n_acc);
    endtask

    initial begin
        vec_t vecs[$];
        int   n_acc;

        // Scenario 1, 2, all-ones, scenario 3 table, disturbance (scenario 4),
        // and a single term (the maxterm build drives raw 16'hFFFE here).
        vecs.push_back('{16'h6EEE, 100, 0, 1'b0, 11});
        vecs.push_back('{16'h0000, 100, 0, 1'b0, 0});
        vecs.push_back('{16'hFFFF, 100, 0, 1'b0, 16});
        vecs.push_back('{16'h8001, 100, 5, 1'b0, 2});
        vecs.push_back('{16'h6EEE, 100, 0, 1'b1, 11});
        vecs.push_back('{16'h0001, 100, 0, 1'b0, 1});
        vecs.push_back('{16'hA5A5,  50, 0, 1'b1, 8});

        rst         = 1'b1;
        start       = 1'b0;
        idx_ready   = 1'b0;
        truth_table = '0;
        step();
        start       = 1'b1;          // must be overridden by reset
        truth_table = 16'hFFFF;
        step();
        check_idle("reset", 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check_idle("idle_hold", 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_scan(vecs[i].sel, vecs[i].ready_pct, vecs[i].hold0,
                     vecs[i].disturb, n_acc);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
        end

        // Scenario 3 in detail: idx 0 held stable while ready stays low.
        truth_table = raw_of(16'h8001);
        start       = 1'b1;
        idx_ready   = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_idx",   int'(idx),       0);
            chk("stall_valid", int'(idx_valid), 1);
            step();
        end
        idx_ready = 1'b1;
        step();
        for (int k = 1; k < TW; k++) step();
        @(negedge clk);
        chk("stall_done",  int'(done),  1);
        chk("stall_count", int'(count), 2);
        step();

        // Scenario 5: reset in the 4th SCAN cycle, then a clean rescan.
        truth_table = raw_of(16'hFFFF);
        start       = 1'b1;
        idx_ready   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_idx", int'(idx), 3);
        step();
        rst = 1'b0;
        check_idle("mid_rst", 0);
        step();
        run_scan(16'hFFFF, 100, 0, 1'b0, n_acc);
        chk("rescan_count", int'(count), 16);

        // Randomized scans against the model.
        for (int r = 0; r < 25; r++) begin
            logic [TW-1:0] sel;
            int expc;
            sel = TW'($urandom);
            if (r % 3 == 0) sel = sel & TW'($urandom);
            expc = $countones(sel);
            run_scan(sel, $urandom_range(30, 100), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), n_acc);
            chk("rand_count", int'(count), expc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_minterm_scanner
